// File: rtl/day_display_pkg.sv
// Shared constants and types for the weekday letter display: letter codes,
// active-high 7-segment glyphs, day indices and the letter bus payload.
package day_display_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIG_W  = 2;

  localparam logic [CODE_W-1:0] C_SPACE = 4'h0;
  localparam logic [CODE_W-1:0] C_A     = 4'h1;
  localparam logic [CODE_W-1:0] C_D     = 4'h2;
  localparam logic [CODE_W-1:0] C_E     = 4'h3;
  localparam logic [CODE_W-1:0] C_F     = 4'h4;
  localparam logic [CODE_W-1:0] C_H     = 4'h5;
  localparam logic [CODE_W-1:0] C_I     = 4'h6;
  localparam logic [CODE_W-1:0] C_N     = 4'h7;
  localparam logic [CODE_W-1:0] C_O     = 4'h8;
  localparam logic [CODE_W-1:0] C_P     = 4'h9;
  localparam logic [CODE_W-1:0] C_R     = 4'hA;
  localparam logic [CODE_W-1:0] C_S     = 4'hB;
  localparam logic [CODE_W-1:0] C_T     = 4'hC;
  localparam logic [CODE_W-1:0] C_U     = 4'hD;

  // Glyph bit order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] G_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] G_A     = 7'h77;
  localparam logic [SEG_W-1:0] G_D     = 7'h5E;
  localparam logic [SEG_W-1:0] G_E     = 7'h79;
  localparam logic [SEG_W-1:0] G_F     = 7'h71;
  localparam logic [SEG_W-1:0] G_H     = 7'h76;
  localparam logic [SEG_W-1:0] G_I     = 7'h06;
  localparam logic [SEG_W-1:0] G_N     = 7'h54;
  localparam logic [SEG_W-1:0] G_O     = 7'h3F;
  localparam logic [SEG_W-1:0] G_P     = 7'h73;
  localparam logic [SEG_W-1:0] G_R     = 7'h50;
  localparam logic [SEG_W-1:0] G_S     = 7'h6D;
  localparam logic [SEG_W-1:0] G_T     = 7'h78;
  localparam logic [SEG_W-1:0] G_U     = 7'h3E;

  typedef enum logic [2:0] {
    MON = 3'd0,
    TUE = 3'd1,
    WED = 3'd2,
    THU = 3'd3,
    FRI = 3'd4,
    SAT = 3'd5,
    SUN = 3'd6
  } day_e;

  typedef struct packed {
    logic [CODE_W-1:0] fourth;
    logic [CODE_W-1:0] third;
    logic [CODE_W-1:0] second;
    logic [CODE_W-1:0] first;
  } letter_bus_t;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  // Select the letter code shown at digit position idx (0 = leftmost).
  function automatic logic [CODE_W-1:0] code_at(letter_bus_t bus, logic [DIG_W-1:0] idx);
    case (idx)
      2'd0:    return bus.first;
      2'd1:    return bus.second;
      2'd2:    return bus.third;
      default: return bus.fourth;
    endcase
  endfunction

endpackage

// File: rtl/letter_seg_decoder.sv
// Combinational letter-code to active-high 7-segment glyph decoder.
// Undefined codes (E, F) decode to a blank digit.
module letter_seg_decoder
  import day_display_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  glyph_c
);

  always_comb begin
    glyph_c = G_BLANK;
    case (code)
      C_SPACE: glyph_c = G_BLANK;
      C_A:     glyph_c = G_A;
      C_D:     glyph_c = G_D;
      C_E:     glyph_c = G_E;
      C_F:     glyph_c = G_F;
      C_H:     glyph_c = G_H;
      C_I:     glyph_c = G_I;
      C_N:     glyph_c = G_N;
      C_O:     glyph_c = G_O;
      C_P:     glyph_c = G_P;
      C_R:     glyph_c = G_R;
      C_S:     glyph_c = G_S;
      C_T:     glyph_c = G_T;
      C_U:     glyph_c = G_U;
      default: glyph_c = G_BLANK;
    endcase
  end

endmodule

// File: rtl/day_letter_display.sv
// Four-digit multiplexed 7-segment display for the weekday letters: shadow
// latch on load, scanned digits with a one-clock anti-ghost blank, optional blink.
module day_letter_display
  import day_display_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned BLINK_TICKS = 256,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [CODE_W-1:0] first_letter,
  input  logic [CODE_W-1:0] second_letter,
  input  logic [CODE_W-1:0] third_letter,
  input  logic [CODE_W-1:0] fourth_letter,
  input  logic              blink_en,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] an,
  output logic [DIG_W-1:0]  cur_digit
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SEG_W-1:0]  SEG_POL = {SEG_W{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};

  letter_bus_t       shadow_q;
  logic [PRE_W-1:0]  presc_q;
  logic [BLK_W-1:0]  blink_cnt_q;
  blink_phase_e      phase_q;
  blink_phase_e      phase_d;
  logic              tick_c;
  logic              blink_wrap_c;
  logic              blank_c;
  logic [CODE_W-1:0] code_c;
  logic [SEG_W-1:0]  glyph_c;
  logic [SEG_W-1:0]  seg_d;
  logic [DIGITS-1:0] an_d;

  assign tick_c       = (presc_q == PRE_W'(CLK_DIV - 1));
  assign blink_wrap_c = (blink_cnt_q == BLK_W'(BLINK_TICKS - 1));
  assign code_c       = code_at(shadow_q, cur_digit);

  letter_seg_decoder u_decoder (
    .code    (code_c),
    .glyph_c (glyph_c)
  );

  // All four letters are captured on the same edge so a digit never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '{fourth: C_SPACE, third: C_SPACE, second: C_SPACE, first: C_SPACE};
    end else if (load) begin
      shadow_q <= '{fourth: fourth_letter, third: third_letter,
                    second: second_letter, first: first_letter};
    end
  end

  // Slot prescaler and scanned-digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      cur_digit <= '0;
    end else if (tick_c) begin
      presc_q   <= '0;
      cur_digit <= cur_digit + DIG_W'(1);
    end else begin
      presc_q   <= presc_q + PRE_W'(1);
    end
  end

  // Counts slot ticks within one blink half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
    end else if (!blink_en) begin
      blink_cnt_q <= '0;
    end else if (tick_c) begin
      blink_cnt_q <= blink_wrap_c ? '0 : blink_cnt_q + BLK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_VISIBLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (!blink_en) begin
      phase_d = PH_VISIBLE;
    end else if (tick_c && blink_wrap_c) begin
      phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
    end
  end

  // Digit goes dark on the slot-change clock and while blink hides it.
  always_comb begin
    seg_d   = G_BLANK;
    an_d    = '0;
    blank_c = tick_c || ((phase_q == PH_HIDDEN) && blink_en);
    if (!blank_c) begin
      an_d  = DIGITS'(1) << cur_digit;
      seg_d = glyph_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_POL;
      an  <= AN_POL;
    end else begin
      seg <= seg_d ^ SEG_POL;
      an  <= an_d ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_day_letter_display.sv
// Scoreboard bench for day_letter_display: active-high and active-low instances
// share stimulus; expectations come from a slot/phase arithmetic model.
module tb_day_letter_display;

  localparam int C = 4;
  localparam int B = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] cur;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] l0 = 4'h0, l1 = 4'h0, l2 = 4'h0, l3 = 4'h0;
  logic [6:0] seg_hi, seg_lo;
  logic [3:0] an_hi, an_lo;
  logic [1:0] cur_hi, cur_lo;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  // Model state: edges since reset, shadow letters, ticks seen with blink on.
  int         k = 0;
  logic [3:0] sh[4];
  int         ticks = 0;
  bit         hidden = 1'b0;

  always #5 clk = ~clk;

  day_letter_display #(.CLK_DIV(C), .BLINK_TICKS(B), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset_n(reset_n), .load(load),
    .first_letter(l0), .second_letter(l1), .third_letter(l2), .fourth_letter(l3),
    .blink_en(blink_en), .seg(seg_hi), .an(an_hi), .cur_digit(cur_hi)
  );

  day_letter_display #(.CLK_DIV(C), .BLINK_TICKS(B), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset_n(reset_n), .load(load),
    .first_letter(l0), .second_letter(l1), .third_letter(l2), .fourth_letter(l3),
    .blink_en(blink_en), .seg(seg_lo), .an(an_lo), .cur_digit(cur_lo)
  );

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h1: return 7'h77;
      4'h2: return 7'h5E;
      4'h3: return 7'h79;
      4'h4: return 7'h71;
      4'h5: return 7'h76;
      4'h6: return 7'h06;
      4'h7: return 7'h54;
      4'h8: return 7'h3F;
      4'h9: return 7'h73;
      4'hA: return 7'h50;
      4'hB: return 7'h6D;
      4'hC: return 7'h78;
      4'hD: return 7'h3E;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    k = 0;
    ticks = 0;
    hidden = 1'b0;
    for (int i = 0; i < 4; i++) sh[i] = 4'h0;
  endfunction

  // Expected outputs after the next clock edge given the inputs sampled there.
  function automatic exp_t model_step(input bit ld, input logic [3:0] c0, input logic [3:0] c1,
                                      input logic [3:0] c2, input logic [3:0] c3, input bit be);
    exp_t e;
    int   dig;
    bit   blank;
    k++;
    dig   = (k / C) % 4;
    blank = ((k % C) == 0) || (hidden && be);
    e.cur = 2'(dig);
    e.an  = blank ? 4'b0000 : 4'(1 << dig);
    e.seg = blank ? 7'h00 : glyph(sh[dig]);
    if (ld) begin
      sh[0] = c0; sh[1] = c1; sh[2] = c2; sh[3] = c3;
    end
    if (!be) ticks = 0;
    else if ((k % C) == 0) ticks++;
    hidden = be && (((ticks / B) % 2) == 1);
    return e;
  endfunction

  task automatic cycle(input bit ld, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [3:0] c2, input logic [3:0] c3, input bit be);
    @(negedge clk);
    reset_n = 1'b1;
    load = ld; l0 = c0; l1 = c1; l2 = c2; l3 = c3;
    blink_en = be;
    exp_q.push_back(model_step(ld, c0, c1, c2, c3, be));
  endtask

  task automatic idle(input int n, input bit be);
    repeat (n) cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, be);
  endtask

  task automatic rst_cycle(input bit async_chk);
    @(negedge clk);
    load = 1'b0;
    blink_en = 1'b0;
    if (async_chk) begin
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_seg_hi", 32'(seg_hi), 32'h00);
      check("async_rst_an_hi",  32'(an_hi),  32'h0);
      check("async_rst_cur_hi", 32'(cur_hi), 32'h0);
      check("async_rst_seg_lo", 32'(seg_lo), 32'h7F);
      check("async_rst_an_lo",  32'(an_lo),  32'hF);
      check("async_rst_cur_lo", 32'(cur_lo), 32'h0);
    end else begin
      reset_n = 1'b0;
    end
    model_reset();
    exp_q.push_back('0);
  endtask

  // Monitor: every active edge presents one output word per instance.
  initial begin
    exp_t       e;
    logic [6:0] seg_inv;
    logic [3:0] an_inv;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seg_inv = ~e.seg;
        an_inv  = ~e.an;
        check("seg_hi", 32'(seg_hi), 32'(e.seg));
        check("an_hi",  32'(an_hi),  32'(e.an));
        check("cur_hi", 32'(cur_hi), 32'(e.cur));
        check("seg_lo", 32'(seg_lo), 32'(seg_inv));
        check("an_lo",  32'(an_lo),  32'(an_inv));
        check("cur_lo", 32'(cur_lo), 32'(e.cur));
      end
    end
  end

  initial begin
    bit         rbe;
    logic [3:0] r0, r1, r2, r3;
    model_reset();
    repeat (3) rst_cycle(1'b0);
    idle(10, 1'b0);
    rst_cycle(1'b1);
    repeat (3) rst_cycle(1'b0);

    // T U E SPACE, then a full scan rotation and a bit more
    cycle(1'b1, 4'hC, 4'hD, 4'h3, 4'h0, 1'b0);
    idle(20, 1'b0);

    // F R I SPACE loaded on the tick edge that leaves digit 3
    while (((k + 1) % (4 * C)) != 0) idle(1, 1'b0);
    cycle(1'b1, 4'h4, 4'hA, 4'h6, 4'h0, 1'b0);
    idle(8, 1'b0);

    // undefined codes everywhere
    cycle(1'b1, 4'hE, 4'hF, 4'hE, 4'hF, 1'b0);
    idle(16, 1'b0);

    // S A T SPACE with blink, then blink dropped
    cycle(1'b1, 4'hB, 4'h1, 4'hC, 4'h0, 1'b1);
    idle(40, 1'b1);
    idle(12, 1'b0);

    rbe = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) rbe = ~rbe;
      if ($urandom_range(0, 299) == 0) begin
        rst_cycle(1'b0);
      end else begin
        r0 = 4'($urandom_range(0, 15));
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
        r3 = 4'($urandom_range(0, 15));
        cycle($urandom_range(0, 7) == 0, r0, r1, r2, r3, rbe);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
